// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port, with a
// registered output stage and read-port bypass while that write is in flight.
module regfile_wb_arbiter #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [4:0]   a_rd,
    input  logic [n-1:0] a_data,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [4:0]   b_rd,
    input  logic [n-1:0] b_data,
    output logic         regWrite,
    output logic [4:0]   writeReg,
    output logic [n-1:0] writeData,
    input  logic [4:0]   readReg1,
    input  logic [4:0]   readReg2,
    output logic         fwd1_hit,
    output logic [n-1:0] fwd1_data,
    output logic         fwd2_hit,
    output logic [n-1:0] fwd2_data
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e       r_last_grant;
    logic         r_reg_write;
    logic [4:0]   r_write_reg;
    logic [n-1:0] r_write_data;

    logic w_open;
    logic w_a_nz, w_b_nz, w_a_x0, w_b_x0;
    logic w_pick_a, w_grant_a, w_grant_b;

    assign w_open = !rst && !stall;
    assign w_a_nz = a_valid && (a_rd != 5'd0);
    assign w_b_nz = b_valid && (b_rd != 5'd0);
    assign w_a_x0 = a_valid && (a_rd == 5'd0);
    assign w_b_x0 = b_valid && (b_rd == 5'd0);

    // A wins when it is the only nonzero requester, or on contention when B went last.
    assign w_pick_a  = w_a_nz && (!w_b_nz || r_last_grant == GRANT_B);
    assign w_grant_a = w_open && w_pick_a;
    assign w_grant_b = w_open && w_b_nz && !w_pick_a;

    // x0 writes are accepted and dropped so they never block the requester.
    assign a_ready = w_grant_a || (w_open && w_a_x0);
    assign b_ready = w_grant_b || (w_open && w_b_x0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GRANT_B;
            r_reg_write  <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= '0;
        end else begin
            r_reg_write <= w_grant_a || w_grant_b;
            if (w_grant_a) begin
                r_last_grant <= GRANT_A;
                r_write_reg  <= a_rd;
                r_write_data <= a_data;
            end else if (w_grant_b) begin
                r_last_grant <= GRANT_B;
                r_write_reg  <= b_rd;
                r_write_data <= b_data;
            end
        end
    end

    assign regWrite  = r_reg_write;
    assign writeReg  = r_write_reg;
    assign writeData = r_write_data;

    assign fwd1_hit  = r_reg_write && (r_write_reg != 5'd0) && (r_write_reg == readReg1);
    assign fwd2_hit  = r_reg_write && (r_write_reg != 5'd0) && (r_write_reg == readReg2);
    assign fwd1_data = fwd1_hit ? r_write_data : '0;
    assign fwd2_data = fwd2_hit ? r_write_data : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, x0 handling, bypass,
// stall and asynchronous reset, with hand-computed expectations.
module tb_regfile_wb_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         a_valid, b_valid;
    logic         a_ready, b_ready;
    logic [4:0]   a_rd, b_rd;
    logic [N-1:0] a_data, b_data;
    logic         regWrite;
    logic [4:0]   writeReg;
    logic [N-1:0] writeData;
    logic [4:0]   readReg1, readReg2;
    logic         fwd1_hit, fwd2_hit;
    logic [N-1:0] fwd1_data, fwd2_data;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.n(N)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .readReg1(readReg1), .readReg2(readReg2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // x0 must never reach the write port.
    always @(negedge clk) begin
        if (rst === 1'b0)
            check("no_x0_write", 32'(regWrite && (writeReg == 5'd0)), 32'd0);
    end

    int ka, kb;
    logic exp_a;

    initial begin
        rst = 1'b1; stall = 1'b0;
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h11;
        b_valid = 1'b0; b_rd = 5'd0; b_data = 32'h0;
        readReg1 = 5'd0; readReg2 = 5'd0;
        #2;
        check("rst_regWrite",  32'(regWrite),  32'd0);
        check("rst_writeReg",  32'(writeReg),  32'd0);
        check("rst_writeData", 32'(writeData), 32'd0);
        check("rst_fwd1_hit",  32'(fwd1_hit),  32'd0);
        check("rst_fwd2_data", 32'(fwd2_data), 32'd0);
        check("rst_a_ready",   32'(a_ready),   32'd0);
        tick;
        a_valid = 1'b0;
        tick;
        rst = 1'b0;

        // Single A write
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h11;
        #1;
        check("t1_a_ready", 32'(a_ready), 32'd1);
        check("t1_b_ready", 32'(b_ready), 32'd0);
        tick;
        a_valid = 1'b0;
        check("t1_regWrite",  32'(regWrite),  32'd1);
        check("t1_writeReg",  32'(writeReg),  32'd5);
        check("t1_writeData", 32'(writeData), 32'h11);
        readReg1 = 5'd5;
        #1;
        check("t1_fwd1_hit",  32'(fwd1_hit),  32'd1);
        check("t1_fwd1_data", 32'(fwd1_data), 32'h11);
        tick;
        check("t1_regWrite_off", 32'(regWrite),  32'd0);
        check("t1_writeReg_hold", 32'(writeReg), 32'd5);
        check("t1_fwd1_off",     32'(fwd1_hit),  32'd0);
        readReg1 = 5'd0;

        // Contention right after reset: A first, then B
        rst = 1'b1;
        #1;
        rst = 1'b0;
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'hB;
        #1;
        check("t2_a_ready", 32'(a_ready), 32'd1);
        check("t2_b_ready", 32'(b_ready), 32'd0);
        tick;
        a_valid = 1'b0;
        check("t2_out1_reg",  32'(writeReg),  32'd3);
        check("t2_out1_data", 32'(writeData), 32'hA);
        #1;
        check("t2_b_ready2", 32'(b_ready), 32'd1);
        tick;
        check("t2_out2_we",   32'(regWrite),  32'd1);
        check("t2_out2_reg",  32'(writeReg),  32'd4);
        check("t2_out2_data", 32'(writeData), 32'hB);

        // Continuous contention: A, B, A, B, A, B
        ka = 0; kb = 0;
        a_valid = 1'b1; a_rd = 5'(10 + ka); a_data = 32'(32'h100 + ka);
        b_valid = 1'b1; b_rd = 5'(20 + kb); b_data = 32'(32'h200 + kb);
        for (int i = 0; i < 6; i++) begin
            exp_a = (i % 2 == 0);
            #1;
            check("t3_a_ready", 32'(a_ready), 32'(exp_a));
            check("t3_b_ready", 32'(b_ready), 32'(!exp_a));
            tick;
            check("t3_regWrite", 32'(regWrite), 32'd1);
            if (exp_a) begin
                check("t3_writeReg_a", 32'(writeReg), 32'(10 + ka));
                ka++;
                a_rd = 5'(10 + ka); a_data = 32'(32'h100 + ka);
            end else begin
                check("t3_writeReg_b", 32'(writeReg), 32'(20 + kb));
                kb++;
                b_rd = 5'(20 + kb); b_data = 32'(32'h200 + kb);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick;
        check("t3_idle", 32'(regWrite), 32'd0);

        // x0 from A alongside nonzero B
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h55;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
        #1;
        check("t4_a_ready", 32'(a_ready), 32'd1);
        check("t4_b_ready", 32'(b_ready), 32'd1);
        tick;
        a_valid = 1'b0; b_valid = 1'b0;
        check("t4_writeReg",  32'(writeReg),  32'd7);
        check("t4_writeData", 32'(writeData), 32'h77);
        // Lone x0 from A: dropped, pointer stays at B
        a_valid = 1'b1; a_rd = 5'd0;
        tick;
        a_valid = 1'b0;
        check("t4_x0_no_write", 32'(regWrite), 32'd0);
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h1;
        b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h2;
        #1;
        check("t4_ptr_a_ready", 32'(a_ready), 32'd1);
        check("t4_ptr_b_ready", 32'(b_ready), 32'd0);
        tick;
        a_valid = 1'b0;
        tick;
        b_valid = 1'b0;
        tick;

        // Bypass on (9, 0x99)
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
        tick;
        b_valid = 1'b0;
        readReg1 = 5'd9; readReg2 = 5'd0;
        #1;
        check("t5_fwd1_hit",  32'(fwd1_hit),  32'd1);
        check("t5_fwd1_data", 32'(fwd1_data), 32'h99);
        check("t5_fwd2_hit",  32'(fwd2_hit),  32'd0);
        check("t5_fwd2_data", 32'(fwd2_data), 32'd0);
        readReg2 = 5'd9;
        #1;
        check("t5_fwd2_hit9", 32'(fwd2_hit), 32'd1);
        tick;
        readReg1 = 5'd0; readReg2 = 5'd0;

        // Stall with both valid; pointer is B so A goes first afterwards
        stall = 1'b1;
        a_valid = 1'b1; a_rd = 5'd12; a_data = 32'hC;
        b_valid = 1'b1; b_rd = 5'd13; b_data = 32'hD;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_stall_a_ready", 32'(a_ready), 32'd0);
            check("t6_stall_b_ready", 32'(b_ready), 32'd0);
            tick;
            check("t6_stall_regWrite", 32'(regWrite), 32'd0);
        end
        stall = 1'b0;
        #1;
        check("t6_rel_a_ready", 32'(a_ready), 32'd1);
        check("t6_rel_b_ready", 32'(b_ready), 32'd0);
        tick;
        a_valid = 1'b0;
        check("t6_out_a", 32'(writeReg), 32'd12);
        tick;
        b_valid = 1'b0;
        check("t6_out_b", 32'(writeReg), 32'd13);
        check("t6_out_b_data", 32'(writeData), 32'hD);
        tick;

        // Asynchronous reset while a write is in flight
        a_valid = 1'b1; a_rd = 5'd6; a_data = 32'h66;
        tick;
        check("t7_pre_regWrite", 32'(regWrite), 32'd1);
        readReg1 = 5'd6;
        rst = 1'b1;
        #1;
        check("t7_rst_regWrite", 32'(regWrite),  32'd0);
        check("t7_rst_writeReg", 32'(writeReg),  32'd0);
        check("t7_rst_fwd1",     32'(fwd1_hit),  32'd0);
        check("t7_rst_a_ready",  32'(a_ready),   32'd0);
        a_valid = 1'b0;
        tick;
        rst = 1'b0;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
